// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: round-robin arbiter sharing one combinational fp_adder among NUM_REQ requesters
module fp_add_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_op,
  output logic [31:0]           add_numberA,
  output logic [31:0]           add_numberB,
  output logic                  add_A_S,
  input  logic [31:0]           add_Result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  busy,
  output logic [15:0]           ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_next;
  logic [ID_W-1:0] last_grant, grant;
  logic found, accept;
  int idx;
  // search starts just after the previous winner so every requester gets a turn
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end
  assign accept = state == IDLE && found && !rst;
  assign req_ready = accept ? NUM_REQ'(1) << grant : '0;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  always_comb begin
    state_next = state;
    state_next = state == IDLE ? (accept ? EXEC : IDLE) :
                 state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
  end
  // operand registers hold after EXEC so the adder inputs stay quiet between ops
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      rsp_id <= '0;
      rsp_result <= '0;
      add_numberA <= '0;
      add_numberB <= '0;
      add_A_S <= 1'b0;
      ops_done <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        add_numberA <= req_a[32*grant +: 32];
        add_numberB <= req_b[32*grant +: 32];
        add_A_S <= req_op[grant];
        rsp_id <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) rsp_result <= add_Result;
      if (rsp_valid && rsp_ready) ops_done <= ops_done + 16'd1;
    end
  end
endmodule

// File: tb/tb_fp_add_scheduler.sv
// tb_fp_add_scheduler: directed table plus hand sequences for the shared fp_adder scheduler
module tb_fp_add_scheduler;
  logic clk, rst;
  logic [3:0] req_valid, req_ready, req_op;
  logic [127:0] req_a, req_b;
  logic [31:0] add_numberA, add_numberB, add_Result, rsp_result;
  logic add_A_S, rsp_valid, rsp_ready, busy;
  logic [1:0] rsp_id;
  logic [15:0] ops_done, exp_ops;
  int tests = 0, fails = 0;

  typedef struct {
    int id;
    logic [31:0] a;
    logic [31:0] b;
    logic op;
    logic [31:0] exp;
    int stall;
  } vec_t;
  vec_t vecs[5];

  fp_add_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .add_numberA(add_numberA), .add_numberB(add_numberB), .add_A_S(add_A_S),
    .add_Result(add_Result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy), .ops_done(ops_done)
  );

  // stand-in adder: exact IEEE results for the known vectors, an order-sensitive hash otherwise
  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b, logic s);
    if (!s && a == 32'h3FC00000 && b == 32'h40300000) return 32'h40880000;
    if (s && a == 32'h41200000 && b == 32'h40B00000) return 32'h40900000;
    if (s && a == 32'h7F800000 && b == 32'h7F800000) return 32'h7FC00000;
    if (!s && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    return {a[15:0], b[31:16]} ^ {31'd0, s} ^ 32'h5A5A0000;
  endfunction
  assign add_Result = fadd(add_numberA, add_numberB, add_A_S);

  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_op(vec_t v);
    req_valid = 4'b1 << v.id;
    req_a[32*v.id +: 32] = v.a;
    req_b[32*v.id +: 32] = v.b;
    req_op[v.id] = v.op;
    rsp_ready = 0;
    #1 chk($sformatf("ready id%0d", v.id), 32'(req_ready), 32'(4'b1 << v.id));
    @(negedge clk);
    req_valid = '0;
    #1 chk("exec busy", 32'(busy), 1);
    chk("exec numberA", add_numberA, v.a);
    chk("exec numberB", add_numberB, v.b);
    chk("exec A_S", 32'(add_A_S), 32'(v.op));
    @(negedge clk);
    #1 chk("rsp valid", 32'(rsp_valid), 1);
    chk("rsp id", 32'(rsp_id), 32'(v.id));
    chk("rsp result", rsp_result, v.exp);
    for (int s = 0; s < v.stall; s++) begin
      req_valid = '1;
      @(negedge clk);
      #1 chk("stall valid", 32'(rsp_valid), 1);
      chk("stall result", rsp_result, v.exp);
      chk("stall id", 32'(rsp_id), 32'(v.id));
      chk("stall ready", 32'(req_ready), 0);
    end
    req_valid = '0;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    exp_ops = exp_ops + 16'd1;
    #1 chk("post valid", 32'(rsp_valid), 0);
    chk("post busy", 32'(busy), 0);
    chk("ops_done", 32'(ops_done), 32'(exp_ops));
    req_valid = '1;
    #1 chk("rr next", 32'(req_ready), 32'(4'b1 << ((v.id + 1) % 4)));
    req_valid = '0;
  endtask

  initial begin
    rst = 1; rsp_ready = 0; req_valid = '1; req_op = '0; req_a = '0; req_b = '0;
    exp_ops = 0;
    vecs[0] = '{2, 32'h3FC00000, 32'h40300000, 1'b0, 32'h40880000, 0};
    vecs[1] = '{0, 32'h41200000, 32'h40B00000, 1'b1, 32'h40900000, 0};
    vecs[2] = '{1, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 0};
    vecs[3] = '{3, 32'h12345678, 32'h9ABCDEF0, 1'b0, fadd(32'h12345678, 32'h9ABCDEF0, 1'b0), 5};
    vecs[4] = '{1, 32'h00000000, 32'h80000000, 1'b1, fadd(32'h00000000, 32'h80000000, 1'b1), 2};
    @(negedge clk); @(negedge clk);
    #1 chk("reset req_ready", 32'(req_ready), 0);
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_id", 32'(rsp_id), 0);
    chk("reset rsp_result", rsp_result, 0);
    chk("reset numberA", add_numberA, 0);
    chk("reset numberB", add_numberB, 0);
    chk("reset A_S", 32'(add_A_S), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset ops_done", 32'(ops_done), 0);
    // contention: all valid, consumer always ready
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = 32'h40000000 + 32'(i);
      req_b[32*i +: 32] = 32'h3F000000 + 32'(i << 8);
      req_op[i] = i[0];
    end
    @(negedge clk);
    rst = 0; rsp_ready = 1;
    for (int n = 0; n < 5; n++) begin
      #1 chk($sformatf("cont grant %0d", n), 32'(req_ready), 32'(4'b1 << (n % 4)));
      @(negedge clk);
      #1 chk("cont exec ready", 32'(req_ready), 0);
      chk("cont exec busy", 32'(busy), 1);
      @(negedge clk);
      #1 chk("cont rsp valid", 32'(rsp_valid), 1);
      chk("cont rsp id", 32'(rsp_id), 32'(n % 4));
      chk("cont rsp result", rsp_result,
          fadd(32'h40000000 + 32'(n % 4), 32'h3F000000 + 32'((n % 4) << 8), 1'(n % 2)));
      chk("cont rsp ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    req_valid = '0; rsp_ready = 0;
    exp_ops = 16'd5;
    #1 chk("cont ops_done", 32'(ops_done), 5);
    foreach (vecs[i]) do_op(vecs[i]);
    // reset during EXEC discards the operation
    @(negedge clk);
    req_valid = 4'b0100;
    req_a[64 +: 32] = 32'h11111111;
    @(negedge clk);
    req_valid = '0;
    #1 chk("mid busy", 32'(busy), 1);
    rst = 1;
    @(negedge clk);
    #1 chk("mid rsp_valid", 32'(rsp_valid), 0);
    chk("mid busy after rst", 32'(busy), 0);
    chk("mid ops_done", 32'(ops_done), 0);
    chk("mid numberA", add_numberA, 0);
    chk("mid rsp_id", 32'(rsp_id), 0);
    rst = 0;
    req_valid = '1;
    #1 chk("mid next grant", 32'(req_ready), 1);
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 chk("mid no rsp", 32'(rsp_valid), 0);
    end
    // wrap: preload the counter near the top, then two real handshakes
    force dut.ops_done = 16'hFFFE;
    #1 release dut.ops_done;
    exp_ops = 16'hFFFE;
    do_op('{0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 0});
    do_op('{1, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 0});
    chk("wrap zero", 32'(ops_done), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
